dl_result_uart_tx: RTL and testbench
====================================

// Module: dl_result_uart_tx
// PURPOSE
// - Result-return path of the delay-line macro: snapshots the tap thermometer code, encodes it, sends it as one UART byte.
// - Sits inside tt_um_ashleyjr_delay_line between the tap capture flops and a uo_out pin.
// - The bench/host receives this byte. Launch side and ui_in decoding live elsewhere.
// PARAMETERS
// - TAPS     32   number of delay-line taps sampled; legal range 1..63
// - CLK_DIV  104  clk cycles per UART bit (12 MHz / 115200); legal >= 2
// PORTS
// - clk       in   1     system clock; sole clock domain
// - rst_n     in   1     reset, asynchronous assert, active low
// - start_i   in   1     request a measurement readout; sampled each clk
// - tap_i     in   TAPS  raw tap levels, asynchronous to clk; bit 0 is nearest the launch point
// - busy_o    out  1     readout in progress; start_i ignored while high
// - done_o    out  1     one-cycle pulse after the stop bit completes
// - code_o    out  8     last encoded result byte; holds until the next encode
// - tx_o      out  1     UART line, 8N1, LSB first, idles high
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - tx_o=1, busy_o=0, done_o=0, code_o=8'h00, state=IDLE.
//   - All capture and count registers are cleared.
//   - A reset mid-frame aborts the frame with no stop bit and no done_o.
// - States: IDLE -> SYNC -> ENC -> START -> DATA -> STOP -> IDLE.
// - IDLE: at an edge N with start_i=1, load tap_i into cap1 and go to SYNC. busy_o=1 from N+1.
// - SYNC: cap2<=cap1 (second flop for metastability). One cycle.
// - ENC:
//   - cnt = popcount(cap2), width 6.
//   - bubble = 1 if any tap k has cap2[k]=1 while some j<k has cap2[j]=0.
//   - code_o <= {bubble, 1'b0, cnt[5:0]}. One cycle.
// - START: tx_o=0 for CLK_DIV cycles. First low cycle begins at edge N+3.
// - DATA: code_o bits 0..7, LSB first, CLK_DIV cycles each. Bit index counter 0..7 wraps into STOP.
// - STOP: tx_o=1 for CLK_DIV cycles. At the end, done_o=1 for one cycle, busy_o=0 and IDLE in the same cycle.
// - Timing: busy_o is high for exactly 3 + 10*CLK_DIV cycles. tx_o is a registered output.
// - Baud counter counts 0..CLK_DIV-1 and reloads on every bit boundary, so there is no drift across the frame.
// - start_i held high continuously starts a new frame the cycle after done_o. There is no queue.
// - start_i while busy_o=1 is dropped; no error flag.
// - All-ones tap input gives cnt=TAPS, bubble=0. All-zeros gives cnt=0, bubble=0.
// STRUCTURE
// - Package dl_pkg:
//   - typedef enum logic [2:0] dl_tx_state_t {IDLE,SYNC,ENC,START,DATA,STOP}
//   - localparam DL_FRAME_BITS=10
//   - localparam DL_CODE_W=8
// - Sub-module dl_thermo_enc:
//   - Combinational, parameter TAPS.
//   - Inputs: code[TAPS-1:0]. Outputs: cnt[5:0], bubble.
//   - Its result is registered in ENC.
// - Top-level file holds the FSM, baud counter, bit counter, sync flops, shift register.
// TESTING (bench CLK_DIV=4, TAPS=32; UART checker samples mid-bit)
// - tap_i=32'h0000_00FF, pulse start_i -> byte 8'h08; busy_o high 43 cycles; done_o single pulse.
// - tap_i=32'hFFFF_FFFF -> 8'h20. tap_i=0 -> 8'h00. Line idles high between frames.
// - tap_i=32'h0000_00F7 (bubble at bit3) -> 8'h87. code_o=8'h87 at ENC+1.
// - Pulse start_i at DATA bit 2 -> no effect; exactly one frame; code_o unchanged.
// - rst_n low during DATA bit 5 -> tx_o=1 and busy_o=0 asynchronously; next start yields a clean frame.
// - start_i held high for 3 frames -> frames back-to-back, START begins 3 cycles after each done_o.

Source files
------------

// File: rtl/dl_pkg.sv
// dl_pkg: shared types and constants for the delay-line result return path.
//   dl_tx_state_t  readout FSM states (capture, encode, UART frame)
//   DL_FRAME_BITS  UART frame length: start + 8 data + stop
//   DL_CODE_W      width of the encoded result byte
package dl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    ENC,
    START,
    DATA,
    STOP
  } dl_tx_state_t;

  localparam int DL_FRAME_BITS = 10;
  localparam int DL_CODE_W     = 8;

endpackage

// File: rtl/dl_thermo_enc.sv
// dl_thermo_enc: combinational thermometer-code encoder.
// Counts the ones in the tap snapshot and flags a "bubble": a set tap sitting
// above a clear tap, which means the snapshot is not a clean thermometer code.
// Ports:
//   code    in  TAPS  tap snapshot, bit 0 nearest the launch point
//   cnt     out 6     number of set taps
//   bubble  out 1     1 if some set tap lies above a clear tap
module dl_thermo_enc #(
  parameter int TAPS = 32
) (
  input  logic [TAPS-1:0] code,
  output logic [5:0]      cnt,
  output logic            bubble
);

  always_comb begin
    logic seen_zero;
    cnt       = '0;
    bubble    = 1'b0;
    seen_zero = 1'b0;
    for (int k = 0; k < TAPS; k++) begin
      cnt = cnt + {5'd0, code[k]};
      if (code[k] && seen_zero) begin
        bubble = 1'b1;
      end
      if (!code[k]) begin
        seen_zero = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dl_result_uart_tx.sv
// dl_result_uart_tx: snapshots the delay-line tap levels on request, encodes
// them into one byte {bubble, 0, popcount} and sends it as an 8N1 UART frame.
// Ports:
//   clk      in   1     system clock
//   rst_n    in   1     asynchronous active-low reset
//   start_i  in   1     readout request, ignored while busy_o is high
//   tap_i    in   TAPS  raw tap levels, asynchronous to clk
//   busy_o   out  1     readout in progress
//   done_o   out  1     one-cycle pulse when the stop bit completes
//   code_o   out  8     last encoded byte, held until the next encode
//   tx_o     out  1     UART line, LSB first, idles high
module dl_result_uart_tx
  import dl_pkg::*;
#(
  parameter int TAPS    = 32,
  parameter int CLK_DIV = 104
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [TAPS-1:0]      tap_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DL_CODE_W-1:0] code_o,
  output logic                 tx_o
);

  localparam int                BAUD_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  // Index of the last data bit (frame minus start and stop bits, minus one).
  localparam logic [2:0]        BIT_LAST  = 3'(DL_FRAME_BITS - 3);

  dl_tx_state_t         state;
  logic [TAPS-1:0]      cap1;
  logic [TAPS-1:0]      cap2;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [2:0]           bit_idx;
  logic [DL_CODE_W-1:0] shreg;
  logic [5:0]           enc_cnt;
  logic                 enc_bubble;
  logic                 baud_last;

  dl_thermo_enc #(
    .TAPS (TAPS)
  ) u_enc (
    .code   (cap2),
    .cnt    (enc_cnt),
    .bubble (enc_bubble)
  );

  assign baud_last = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cap1     <= '0;
      cap2     <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      code_o   <= '0;
      tx_o     <= 1'b1;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            cap1   <= tap_i;
            busy_o <= 1'b1;
            state  <= SYNC;
          end
        end
        SYNC: begin
          // Second flop of the synchroniser for the asynchronous tap levels.
          cap2  <= cap1;
          state <= ENC;
        end
        ENC: begin
          code_o   <= {enc_bubble, 1'b0, enc_cnt};
          shreg    <= {enc_bubble, 1'b0, enc_cnt};
          baud_cnt <= '0;
          bit_idx  <= '0;
          state    <= START;
        end
        START: begin
          // The line is still high on the first START cycle; that cycle
          // drives the start bit low and the baud count begins after it,
          // so the start bit gets its full CLK_DIV cycles.
          if (tx_o) begin
            tx_o     <= 1'b0;
            baud_cnt <= '0;
          end else if (baud_last) begin
            baud_cnt <= '0;
            tx_o     <= shreg[0];
            shreg    <= shreg >> 1;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              bit_idx <= '0;
              tx_o    <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_o    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            done_o   <= 1'b1;
            busy_o   <= 1'b0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dl_result_uart_tx.sv
module tb_dl_result_uart_tx;

  localparam int TAPS     = 32;
  localparam int CLK_DIV  = 4;
  localparam int BUSY_LEN = 3 + 10 * CLK_DIV;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [31:0] tap_i;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  code_o;
  logic        tx_o;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  int accepted  = 0;
  int aborted   = 0;
  int done_cnt  = 0;
  int rx_frames = 0;

  // receiver / monitor state
  int         rx_k;
  logic       rx_on;
  logic       rx_prev;
  logic [7:0] rx_byte;
  int         busy_run;
  logic       prev_done;

  dl_result_uart_tx #(
    .TAPS    (TAPS),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .tap_i   (tap_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .code_o  (code_o),
    .tx_o    (tx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: byte = {not-a-clean-thermometer, 0, number of ones}.
  function automatic logic [7:0] model(input logic [31:0] t);
    int          c;
    logic [32:0] clean;
    logic        bub;
    c     = $countones(t);
    clean = (33'd1 << c) - 33'd1;
    bub   = ({1'b0, t} != clean);
    return {bub, 1'b0, 6'(c)};
  endfunction

  // UART receiver: samples mid-bit, pops the scoreboard at the stop bit.
  initial begin
    rx_on   = 1'b0;
    rx_prev = 1'b1;
    rx_k    = 0;
    rx_byte = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rx_on   = 1'b0;
        rx_prev = 1'b1;
      end else begin
        if (!rx_on) begin
          if (rx_prev && !tx_o) begin
            rx_on = 1'b1;
            rx_k  = 0;
          end
        end else begin
          rx_k++;
        end
        if (rx_on) begin
          if (rx_k == 2) begin
            chk("start_bit", tx_o, 1'b0);
          end else if (rx_k >= 6 && rx_k <= 34 && ((rx_k - 2) % 4) == 0) begin
            rx_byte[(rx_k - 2) / 4 - 1] = tx_o;
          end else if (rx_k == 38) begin
            chk("stop_bit", tx_o, 1'b1);
            rx_frames++;
            if (exp_q.size() == 0) begin
              chk("unexpected_frame", 32'(rx_frames), 32'(accepted - aborted));
            end else begin
              chk("rx_byte", rx_byte, exp_q.pop_front());
            end
            rx_on = 1'b0;
          end
        end
        rx_prev = tx_o;
      end
    end
  end

  // busy length and done pulse monitor
  initial begin
    busy_run  = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_run  = 0;
        prev_done = 1'b0;
      end else begin
        if (done_o) begin
          done_cnt++;
          chk("done_busy_low", busy_o, 1'b0);
          chk("done_line_high", tx_o, 1'b1);
          chk("done_single", prev_done, 1'b0);
        end
        if (busy_o) begin
          busy_run++;
        end else if (busy_run > 0) begin
          chk("busy_len", 32'(busy_run), 32'(BUSY_LEN));
          busy_run = 0;
        end
        prev_done = done_o;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Issue one start pulse from idle; checks code_o right after the encode cycle.
  task automatic send(input logic [31:0] t);
    logic [7:0] e;
    wait_idle();
    e       = model(t);
    tap_i   = t;
    start_i = 1'b1;
    exp_q.push_back(e);
    accepted++;
    @(negedge clk);
    start_i = 1'b0;
    tap_i   = $urandom;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("code_enc", code_o, e);
  endtask

  initial begin
    logic [31:0] t;
    logic [7:0]  held;
    int          n;
    rst_n   = 1'b0;
    start_i = 1'b0;
    tap_i   = '0;
    #12;
    chk("rst_tx", tx_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_code", code_o, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // directed patterns
    send(32'h0000_00FF);
    send(32'hFFFF_FFFF);
    send(32'h0000_0000);
    send(32'h0000_00F7);

    // start during DATA bit 2 is dropped
    send(32'h0000_0007);
    repeat (12) @(posedge clk);
    @(negedge clk);
    start_i = 1'b1;
    tap_i   = 32'hFFFF_0000;
    @(negedge clk);
    start_i = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    chk("drop_busy", busy_o, 1'b0);
    chk("drop_code", code_o, model(32'h0000_0007));

    // reset during DATA bit 5 aborts the frame
    send(32'h0000_003F);
    repeat (25) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_tx", tx_o, 1'b1);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_done", done_o, 1'b0);
    chk("abort_code", code_o, 8'h00);
    exp_q.delete();
    aborted++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h0000_00FF);

    // start held high: three back-to-back frames
    wait_idle();
    tap_i   = 32'h0000_0FFF;
    held    = model(tap_i);
    start_i = 1'b1;
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back(held);
      accepted++;
    end
    for (int f = 0; f < 3; f++) begin
      n = 0;
      @(negedge clk);
      while (!done_o && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!done_o) begin
        chk("b2b_timeout", 32'd1, 32'd0);
        break;
      end
      if (f == 2) begin
        start_i = 1'b0;
      end else begin
        @(negedge clk);
        chk("b2b_busy", busy_o, 1'b1);
        repeat (3) @(negedge clk);
        chk("b2b_start", tx_o, 1'b0);
      end
    end

    // randomized frames
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        t = $urandom;
      end else begin
        n = $urandom_range(0, 32);
        t = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        if ($urandom_range(0, 1) == 1) t[$urandom_range(0, 31)] ^= 1'b1;
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(t);
    end

    wait_idle();
    repeat (6) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_count", 32'(done_cnt), 32'(accepted - aborted));
    chk("rx_count", 32'(rx_frames), 32'(accepted - aborted));
    chk("final_line_idle", tx_o, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
